// File: rtl/div24_pkg.sv
// -----------------------------------------------------------------------------
// div24_pkg
// Shared definitions for the iterative signed 24-bit divider.
//   W              operand / result width
//   CNT_W          width of the step counter (counts W-1 down to 0)
//   div24_state_e  FSM state encoding (IDLE, CALC, DONE)
//   DIV24_MIN      most negative operand, 24'h800000
//   DIV24_MAX      most positive operand, 24'h7FFFFF
//   DIV24_NEG1     -1, used to detect the single overflowing quotient
//   cond_neg()     two's-complement negate when the select bit is set
// -----------------------------------------------------------------------------
package div24_pkg;

  localparam int W     = 24;
  localparam int CNT_W = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div24_state_e;

  localparam logic [W-1:0] DIV24_MIN  = 24'h800000;
  localparam logic [W-1:0] DIV24_MAX  = 24'h7FFFFF;
  localparam logic [W-1:0] DIV24_NEG1 = 24'hFFFFFF;

  // Negating DIV24_MIN yields DIV24_MIN again; read as unsigned that is
  // exactly 2^23, which is why magnitudes fit in W unsigned bits.
  function automatic logic [W-1:0] cond_neg(input logic neg, input logic [W-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div24_step.sv
// -----------------------------------------------------------------------------
// div24_step
// One purely combinational radix-2 restoring division step on magnitudes.
//   rem_i  partial remainder entering the step (always < div_i)
//   bit_i  next dividend bit, shifted in at the LSB
//   div_i  divisor magnitude (non-zero, at most 2^23)
//   rem_o  partial remainder after the step
//   q_o    quotient bit produced by this step
// -----------------------------------------------------------------------------
module div24_step
  import div24_pkg::*;
(
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] div_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0]   trial;
  logic [W-1:0] diff;

  // The trial value needs W+1 bits for the compare, but when the subtraction
  // is taken the result is below div_i, so the low W bits of the difference
  // are exact under modular arithmetic.
  assign trial = {rem_i, bit_i};
  assign q_o   = (trial >= {1'b0, div_i});
  assign diff  = trial[W-1:0] - div_i;
  assign rem_o = q_o ? diff : trial[W-1:0];

endmodule

// File: rtl/div24_seq.sv
// -----------------------------------------------------------------------------
// div24_seq
// Iterative signed 24-bit divider: quotient truncates toward zero, remainder
// takes the sign of the dividend (SystemVerilog / and % on signed operands).
// One restoring step per clock on operand magnitudes, then a sign fix.
//
// Build option: define DIV24_REM_EN to expose the signed remainder on 'rem'.
// Without it the port and its sign-fix logic are absent; the internal
// partial remainder is still kept because the algorithm needs it.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake (a, b)
//   out_valid/out_ready  result handshake (quot, rem, div_by_zero, overflow)
//   state_o        current FSM state, for observation
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high. in_ready is high only in IDLE and out_valid only in DONE,
// so an operand accept and a result hand-off never share a cycle. While
// out_valid is high and out_ready low, every result output holds still.
// -----------------------------------------------------------------------------
module div24_seq
  import div24_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quot,
`ifdef DIV24_REM_EN
  output logic [W-1:0] rem,
`endif
  output logic         div_by_zero,
  output logic         overflow,
  output logic [1:0]   state_o
);

  div24_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  // dvd_q starts as |a|; each step shifts one dividend bit out of the top and
  // one quotient bit in at the bottom, so after W steps it holds |quotient|.
  logic [W-1:0]     dvd_q;
  logic [W-1:0]     dvs_q;
  logic [W-1:0]     prem_q;
  logic             sign_q_q;
  logic [W-1:0]     quot_q;
  logic             dbz_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;
`ifdef DIV24_REM_EN
  logic             sign_a_q;
  logic [W-1:0]     rem_q;
`endif

  logic [W-1:0] a_mag;
  logic [W-1:0] b_mag;
  logic [W-1:0] step_rem;
  logic         step_q;
  logic [W-1:0] quot_next;

  assign a_mag = cond_neg(a[W-1], a);
  assign b_mag = cond_neg(b[W-1], b);

  div24_step u_step (
    .rem_i (prem_q),
    .bit_i (dvd_q[W-1]),
    .div_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  assign quot_next = {dvd_q[W-2:0], step_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      sign_q_q    <= 1'b0;
      quot_q      <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef DIV24_REM_EN
      sign_a_q    <= 1'b0;
      rem_q       <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
            in_ready_q <= 1'b0;
            if (b == '0) begin
              // Divide by zero saturates toward the dividend's sign.
              dbz_q       <= 1'b1;
              quot_q      <= a[W-1] ? DIV24_MIN : DIV24_MAX;
`ifdef DIV24_REM_EN
              rem_q       <= a;
`endif
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else if (a == DIV24_MIN && b == DIV24_NEG1) begin
              // +2^23 is not representable; saturate.
              ovf_q       <= 1'b1;
              quot_q      <= DIV24_MAX;
`ifdef DIV24_REM_EN
              rem_q       <= '0;
`endif
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              dvd_q    <= a_mag;
              dvs_q    <= b_mag;
              prem_q   <= '0;
              sign_q_q <= a[W-1] ^ b[W-1];
`ifdef DIV24_REM_EN
              sign_a_q <= a[W-1];
`endif
              cnt_q    <= CNT_W'(W - 1);
              state_q  <= CALC;
            end
          end
        end

        CALC: begin
          dvd_q  <= quot_next;
          prem_q <= step_rem;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            // Last step: take the step outputs directly and apply signs so
            // the result is ready on the same edge that enters DONE.
            quot_q      <= cond_neg(sign_q_q, quot_next);
`ifdef DIV24_REM_EN
            rem_q       <= cond_neg(sign_a_q, step_rem);
`endif
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quot        = quot_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
  assign state_o     = state_q;
`ifdef DIV24_REM_EN
  assign rem         = rem_q;
`endif

endmodule

// File: tb/tb_div24_seq.sv
module tb_div24_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] a;
  logic [23:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] quot;
  logic [23:0] rem_w;
  logic        div_by_zero;
  logic        overflow;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  div24_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quot        (quot),
`ifdef DIV24_REM_EN
    .rem         (rem_w),
`endif
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .state_o     (state_dbg)
  );

`ifndef DIV24_REM_EN
  assign rem_w = '0;
`endif

  // ---------------- reference model ----------------
  // Plain signed integer arithmetic plus the two saturating special cases.
  function automatic void ref_div(input logic [23:0] av, input logic [23:0] bv,
                                  output logic [23:0] q, output logic [23:0] r,
                                  output logic dbz, output logic ovf);
    int sa, sb;
    sa  = $signed(av);
    sb  = $signed(bv);
    dbz = 1'b0;
    ovf = 1'b0;
    if (sb == 0) begin
      dbz = 1'b1;
      q   = (sa < 0) ? 24'h800000 : 24'h7FFFFF;
      r   = av;
    end else if (sa == -8388608 && sb == -1) begin
      ovf = 1'b1;
      q   = 24'h7FFFFF;
      r   = 24'h0;
    end else begin
      q = 24'(sa / sb);
      r = 24'(sa % sb);
    end
  endfunction

  // ---------------- driver tasks ----------------
  // Called from IDLE, #1 after a rising edge. Returns with the result on the
  // outputs (or timed out) and out_ready still low. lat counts rising edges
  // after the accepting edge until out_valid is seen.
  task automatic run_op(input logic [23:0] av, input logic [23:0] bv,
                        output logic [23:0] q, output logic [23:0] r,
                        output logic dbz, output logic ovf,
                        output int lat, output logic to);
    in_valid = 1'b1;
    a = av;
    b = bv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 24'($urandom);
    b = 24'($urandom);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    to  = !out_valid;
    q   = quot;
    r   = rem_w;
    dbz = div_by_zero;
    ovf = overflow;
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1)    begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (quot !== 24'h0)       begin bad++; $display("FAIL reset_quot got=%h exp=000000", quot); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    total++; if (overflow !== 1'b0)    begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    total++; if (state_dbg !== 2'd0)   begin bad++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
`ifdef DIV24_REM_EN
    total++; if (rem_w !== 24'h0)      begin bad++; $display("FAIL reset_rem got=%h exp=000000", rem_w); end
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Directed cases with hand-derived answers (normal and special paths).
  task automatic test_directed();
    logic [23:0] av, bv, eq, er, q, r;
    logic edbz, eovf, dbz, ovf, to;
    int elat, lat;
    for (int i = 0; i < 7; i++) begin
      edbz = 1'b0; eovf = 1'b0; elat = 24;
      case (i)
        0: begin av = 24'd100;      bv = 24'd7;      eq = 24'd14;       er = 24'd2;       end
        1: begin av = 24'(-100);    bv = 24'd7;      eq = 24'(-14);     er = 24'(-2);     end
        2: begin av = 24'd100;      bv = 24'(-7);    eq = 24'(-14);     er = 24'd2;       end
        3: begin av = 24'h800000;   bv = 24'd1;      eq = 24'h800000;   er = 24'd0;       end
        4: begin av = 24'd5;        bv = 24'd0;      eq = 24'h7FFFFF;   er = 24'd5;       edbz = 1'b1; elat = 0; end
        5: begin av = 24'(-5);      bv = 24'd0;      eq = 24'h800000;   er = 24'(-5);     edbz = 1'b1; elat = 0; end
        default: begin av = 24'h800000; bv = 24'hFFFFFF; eq = 24'h7FFFFF; er = 24'd0;   eovf = 1'b1; elat = 0; end
      endcase
      run_op(av, bv, q, r, dbz, ovf, lat, to);
      total++; if (to)          begin bad++; $display("FAIL dir%0d_timeout got=no_out_valid exp=out_valid", i); end
      total++; if (q !== eq)    begin bad++; $display("FAIL dir%0d_quot got=%h exp=%h", i, q, eq); end
      total++; if (dbz !== edbz) begin bad++; $display("FAIL dir%0d_dbz got=%b exp=%b", i, dbz, edbz); end
      total++; if (ovf !== eovf) begin bad++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, ovf, eovf); end
      total++; if (lat != elat) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, elat); end
`ifdef DIV24_REM_EN
      total++; if (r !== er)    begin bad++; $display("FAIL dir%0d_rem got=%h exp=%h", i, r, er); end
`endif
      finish_op();
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] av, bv, eq, er, q, r;
    logic edbz, eovf, dbz, ovf, to;
    int lat;
    av = 24'($urandom);
    bv = 24'($urandom_range(3, 4000));
    ref_div(av, bv, eq, er, edbz, eovf);
    run_op(av, bv, q, r, dbz, ovf, lat, to);
    total++; if (to) begin bad++; $display("FAIL bp_timeout got=no_out_valid exp=out_valid"); end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      total++; if (quot !== eq)        begin bad++; $display("FAIL bp_quot c%0d got=%h exp=%h", c, quot, eq); end
      total++; if (div_by_zero !== edbz || overflow !== eovf)
                                       begin bad++; $display("FAIL bp_flags c%0d got=%b%b exp=%b%b", c, div_by_zero, overflow, edbz, eovf); end
      total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL bp_in_ready c%0d got=%b exp=0", c, in_ready); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid c%0d got=%b exp=1", c, out_valid); end
`ifdef DIV24_REM_EN
      total++; if (rem_w !== er)       begin bad++; $display("FAIL bp_rem c%0d got=%h exp=%h", c, rem_w, er); end
`endif
    end
    finish_op();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_random();
    logic [23:0] av, bv, eq, er, q, r;
    logic edbz, eovf, dbz, ovf, to;
    int lat, elat, sel;
    for (int i = 0; i < 100; i++) begin
      sel = $urandom_range(0, 9);
      av  = 24'($urandom);
      bv  = 24'($urandom);
      case (sel)
        0: bv = 24'h0;
        1: begin av = 24'h800000; bv = 24'hFFFFFF; end
        2: bv = 24'($urandom_range(1, 15));
        3: bv = 24'(-$signed(32'($urandom_range(1, 15))));
        4: av = 24'h800000;
        5: av = 24'($urandom_range(0, 20));
        default: ;
      endcase
      ref_div(av, bv, eq, er, edbz, eovf);
      elat = (edbz || eovf) ? 0 : 24;
      run_op(av, bv, q, r, dbz, ovf, lat, to);
      total++; if (to)          begin bad++; $display("FAIL rnd%0d_timeout a=%h b=%h", i, av, bv); end
      total++; if (q !== eq)    begin bad++; $display("FAIL rnd%0d_quot a=%h b=%h got=%h exp=%h", i, av, bv, q, eq); end
      total++; if (dbz !== edbz || ovf !== eovf)
                                begin bad++; $display("FAIL rnd%0d_flags a=%h b=%h got=%b%b exp=%b%b", i, av, bv, dbz, ovf, edbz, eovf); end
      total++; if (lat != elat) begin bad++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, elat); end
`ifdef DIV24_REM_EN
      total++; if (r !== er)    begin bad++; $display("FAIL rnd%0d_rem a=%h b=%h got=%h exp=%h", i, av, bv, r, er); end
`endif
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
      finish_op();
    end
  endtask

  // Two special-case operations with out_ready held high: 2-cycle interval.
  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = 24'd7;
    b = 24'd0;
    @(posedge clk); #1;
    a = 24'(-9);
    total++; if (out_valid !== 1'b1 || quot !== 24'h7FFFFF)
      begin bad++; $display("FAIL b2b_first got=%b/%h exp=1/7fffff", out_valid, quot); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL b2b_gap got=%b/%b exp=0/1", out_valid, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || quot !== 24'h800000 || div_by_zero !== 1'b1)
      begin bad++; $display("FAIL b2b_second got=%b/%h/%b exp=1/800000/1", out_valid, quot, div_by_zero); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle got=%b exp=1", in_ready); end
  endtask

  task automatic test_reset_mid_calc();
    logic [23:0] q, r;
    logic dbz, ovf, to, seen;
    int lat;
    in_valid = 1'b1;
    a = 24'd100;
    b = 24'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
    total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL rstmid_state got=%0d exp=0", state_dbg); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_stale_result got=emitted exp=discarded"); end
    run_op(24'd100, 24'd7, q, r, dbz, ovf, lat, to);
    total++; if (to || q !== 24'd14) begin bad++; $display("FAIL rstmid_next_quot got=%h exp=00000e", q); end
    total++; if (dbz !== 1'b0 || ovf !== 1'b0) begin bad++; $display("FAIL rstmid_next_flags got=%b%b exp=00", dbz, ovf); end
`ifdef DIV24_REM_EN
    total++; if (r !== 24'd2) begin bad++; $display("FAIL rstmid_next_rem got=%h exp=000002", r); end
`endif
    finish_op();
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_calc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
